// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the iterative Booth multiplier.
package mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // One iteration per bit of the (WIDTH+1)-bit extended multiplier.
  function automatic int unsigned iter_count(input int unsigned width);
    return width + 1;
  endfunction

  // Counter wide enough to hold the iteration count itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the shifted
// multiplicand, then an arithmetic shift right by one.
module booth_step #(
  parameter int unsigned PW = 67
) (
  input  logic [PW-1:0] p,
  input  logic [PW-1:0] add,
  input  logic [PW-1:0] sub,
  output logic [PW-1:0] p_next
);

  logic [PW-1:0] sum;

  always_comb begin
    sum = p;
    unique case (p[1:0])
      2'b01:   sum = p + add;
      2'b10:   sum = p + sub;
      default: sum = p;
    endcase
    p_next = $unsigned($signed(sum) >>> 1);
  end

endmodule

// File: rtl/booth_mult_unit.sv
// Iterative radix-2 Booth multiplier for the HI/LO unit: signed/unsigned,
// operands latched on Start, fixed WIDTH+1 cycle latency, Busy/Done handshake.
module booth_mult_unit
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int unsigned N     = iter_count(WIDTH);
  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam int unsigned EW    = WIDTH + 1;
  localparam int unsigned ZW    = WIDTH + 2;
  localparam int unsigned PW    = 2 * WIDTH + 3;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]      p_q, p_d;
  logic [PW-1:0]      add_q, add_d;
  logic [PW-1:0]      sub_q, sub_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [PW-1:0]      p_step;
  logic [EW-1:0]      m_ext;
  logic [EW-1:0]      b_ext;

  // The extra top bit keeps -M representable for the most negative operand.
  assign m_ext = {Signed & A[WIDTH-1], A};
  assign b_ext = {Signed & B[WIDTH-1], B};

  booth_step #(
    .PW(PW)
  ) u_step (
    .p     (p_q),
    .add   (add_q),
    .sub   (sub_q),
    .p_next(p_step)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      add_q   <= '0;
      sub_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      add_q   <= add_d;
      sub_q   <= sub_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state: accept in IDLE only, so Start while busy never touches operands.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    add_d   = add_q;
    sub_d   = sub_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          p_d     = {EW'(0), b_ext, 1'b0};
          add_d   = {m_ext, ZW'(0)};
          sub_d   = {EW'(0) - m_ext, ZW'(0)};
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        p_d = p_step;
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hi_d    = p_step[2*WIDTH:WIDTH+1];
          lo_d    = p_step[WIDTH:1];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule
